// File: rtl/paper_proc_pkg.sv
// Shared definitions for the paper processor: opcode encodings and the
// pulse stretcher state type.
package paper_proc_pkg;

   localparam int OP_WIDTH = 2;

   typedef logic [OP_WIDTH-1:0] op_t;

   localparam op_t OP_INC = 2'b00;
   localparam op_t OP_JNO = 2'b01;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_STRETCH = 1'b1
   } stretch_state_e;

endpackage

// File: rtl/pc_step_unit_pulse_stretcher.sv
// Rise detector plus IDLE/STRETCH monostable: a qualified rising edge of
// pulse fires a busy window of exactly PULSE_LEN cycles.
module pulse_stretcher
   import paper_proc_pkg::*;
#(
   parameter int PULSE_LEN = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse,
   input  logic trig_en,
   output logic rise,
   output logic fire,
   output logic busy
);

   localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   stretch_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q;
   logic             done;

   assign rise = pulse & ~pulse_q;
   assign done = (state_q == ST_STRETCH) && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pulse_q <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         pulse_q <= pulse;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               state_d = ST_STRETCH;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_STRETCH: begin
            if (fire) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The last strobe cycle already counts as free, so a new trigger can
   // land exactly PULSE_LEN edges after the previous one.
   always_comb begin
      busy = (state_q == ST_STRETCH);
      fire = rise & trig_en & ((state_q == ST_IDLE) | done);
   end

endmodule

// File: rtl/pc_step_unit.sv
// Clocked PC step/jump unit: INC adds STEP with sticky carry status and a
// monostable strobe, JNO loads a target unless overflow is pending.
// Optional PC_STEP_SATURATE_EN clamps the count at all-ones on carry-out.
module pc_step_unit
   import paper_proc_pkg::*;
#(
   parameter int              WIDTH     = 2,
   parameter int              OP_W      = 2,
   parameter logic [OP_W-1:0] INC_OP    = OP_INC,
   parameter logic [OP_W-1:0] JNO_OP    = OP_JNO,
   parameter int              STEP      = 1,
   parameter int              PULSE_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse,
   input  logic [OP_W-1:0]  instr_op,
   input  logic [WIDTH-1:0] jump_target,
   output logic [WIDTH-1:0] adder_to_out,
   output logic             adder_to_status,
   output logic             monostable,
   output logic             busy
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             status_q, status_d;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             rise, inc_fire, jno_fire, stretch_busy;

   pulse_stretcher #(
      .PULSE_LEN (PULSE_LEN)
   ) u_stretch (
      .clk     (clk),
      .reset   (reset),
      .pulse   (pulse),
      .trig_en (instr_op == INC_OP),
      .rise    (rise),
      .fire    (inc_fire),
      .busy    (stretch_busy)
   );

   assign jno_fire = rise & (instr_op == JNO_OP);
   assign sum      = {1'b0, cnt_q} + (WIDTH+1)'(STEP);
   assign carry    = sum[WIDTH];

   always_comb begin
      cnt_d    = cnt_q;
      status_d = status_q;
      if (inc_fire) begin
         if (carry) status_d = 1'b1;
`ifdef PC_STEP_SATURATE_EN
         cnt_d = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
         cnt_d = sum[WIDTH-1:0];
`endif
      end else if (jno_fire) begin
         // A pending overflow consumes the jump: the count holds and the flag clears.
         if (!status_q) cnt_d = jump_target;
         else           status_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         status_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

   assign adder_to_out    = cnt_q;
   assign adder_to_status = status_q;
   assign busy            = stretch_busy;
   assign monostable      = stretch_busy;

endmodule

// File: doc/pc_step_unit.md
# pc_step_unit

Parametrised step/jump unit for the paper processor program counter. On each rising edge of the step `pulse` it decodes the current opcode and does one of two things. On INC it adds a step value to the held count and raises a fixed-length `monostable` strobe. On JNO it loads a jump target if no overflow is pending. It sits between the instruction register and the PC register file, replacing the fixed 2-bit increment path with a clocked, width-generic one that keeps a sticky overflow status.

## Interface
- `WIDTH`, 2: count / target width in bits (≥2)
- `OP_W`, 2: opcode width
- `INC_OP`, 2'b00: opcode that triggers an increment
- `JNO_OP`, 2'b01: opcode that triggers a jump-if-no-overflow
- `STEP`, 1: increment amount, 1 ≤ STEP < 2^WIDTH
- `PULSE_LEN`, 2: monostable strobe length in cycles (≥1)

Ports:
- `clk`, in, 1: single clock, all logic on rising edge
- `reset`, in, 1: synchronous, active-high
- `pulse`, in, 1: step request, level; only its rising edge acts
- `instr_op`, in, OP_W: opcode, sampled in the cycle the rising edge is detected
- `jump_target`, in, WIDTH: JNO load value
- `adder_to_out`, out, WIDTH: held count
- `adder_to_status`, out, 1: sticky overflow flag
- `monostable`, out, 1: strobe, high PULSE_LEN cycles per accepted INC
- `busy`, out, 1: high while the strobe is active

## Operation
- Edge detect: `pulse_q` registers `pulse`. `rise = pulse & ~pulse_q`.
- FSM states:
  - IDLE: on `rise` with `instr_op==INC_OP`, go to STRETCH.
  - STRETCH: a counter loads PULSE_LEN-1 on entry and decrements each cycle. Return to IDLE when it is 0.
- INC accept (rise, INC_OP, IDLE):
  - `adder_to_out <= adder_to_out + STEP` (mod 2^WIDTH).
  - If the carry-out is 1, set `adder_to_status <= 1`.
  - Status stays set until cleared; it is never cleared by INC.
- JNO accept (rise, JNO_OP, any state):
  - If status is 0: `adder_to_out <= jump_target`.
  - If status is 1: count unchanged, status cleared to 0.
  - No strobe; FSM state unaffected.
- Other opcodes on `rise`: no effect.
- Rise with INC_OP while in STRETCH: ignored. Count, status and counter are unchanged; the strobe is not retriggered.
- `busy` = (state==STRETCH). `monostable` = `busy`.
- Reset (any time, including mid-strobe) has priority over every other event. All outputs and `pulse_q` go to 0, FSM to IDLE, counter to 0.

## Timing
- `rise` is decided at edge N, where `pulse`=1 is sampled and `pulse_q`=0.
- Count/status update is visible after edge N.
- `monostable` is high for exactly PULSE_LEN cycles after edge N, then low after edge N+PULSE_LEN.
- Back-to-back INC: the earliest accepted second rise is at edge N+PULSE_LEN. That requires `pulse` low at edge N+PULSE_LEN-1 or earlier.
- `pulse` held high produces exactly one rise.
- JNO latency is 1 cycle. JNO during STRETCH does not shorten the strobe.

## Configuration
- `PC_STEP_SATURATE_EN` defined:
  - On carry-out, `adder_to_out <= {WIDTH{1'b1}}` instead of the wrapped sum.
  - Status is set as normal.
  - Once at max, further INCs hold max and still strobe.
- Not defined: modular wrap-around, e.g. 2'b11 + 1 → 2'b00 with status set.

## Structure
- Shared package `paper_proc_pkg`: opcode constants `OP_INC`, `OP_JNO` and the `op_t` typedef of width OP_W. Parameter defaults reference these.
- One sub-module, `pulse_stretcher`: owns the rise detector, IDLE/STRETCH FSM and down-counter. It is parameterised by PULSE_LEN, takes a trigger enable in, and gives `busy` out.
- The add/saturate datapath and JNO mux stay in `pc_step_unit`.

## Test plan
All cases use defaults (WIDTH=2, STEP=1, PULSE_LEN=2).
- Reset then INC: count 0, pulse rises with op 00 → count 1, `monostable` high 2 cycles, status 0.
- Wrap: three INCs from 1 → counts 2, 3, then 0 with status 1. With `PC_STEP_SATURATE_EN`, the last INC gives 3 with status 1.
- JNO with status 0, target 2'b10: op 01 rise → count 2 next cycle, no strobe. JNO with status 1 → count unchanged, status 0.
- Retrigger while busy: second INC rise one cycle after the first → ignored. Count advances by 1 only; strobe is exactly 2 cycles.
- `pulse` held high 5 cycles with INC → exactly one increment and one 2-cycle strobe.
- Reset asserted in the 1st strobe cycle → next cycle count 0, status 0, `monostable` 0, `busy` 0. An INC rise after deassert works normally.
